// File: rtl/uart_rx_deser_if.sv
// Bundle between the bit sampler/consumer (master) and uart_rx_deser (slave).
// Parity signals exist only when DESER_PARITY_EN is defined.
interface uart_rx_deser_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sampled_bit;
  logic                  deser_en;
  logic                  frame_start;
  logic                  msb_first;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  overrun;
`ifdef DESER_PARITY_EN
  logic                  par_type;
  logic                  par_err;
`endif

  modport master (
    output sampled_bit, output deser_en, output frame_start, output msb_first,
    output data_ready,
`ifdef DESER_PARITY_EN
    output par_type, input par_err,
`endif
    input P_DATA, input data_valid, input overrun
  );

  modport slave (
    input sampled_bit, input deser_en, input frame_start, input msb_first,
    input data_ready,
`ifdef DESER_PARITY_EN
    input par_type, output par_err,
`endif
    output P_DATA, output data_valid, output overrun
  );
endinterface

// File: rtl/uart_rx_deser.sv
// Serial-to-parallel deserializer for the UART RX path with valid/ready output and overrun pulse.
// Define DESER_PARITY_EN to add a parity-bit slot after each word and a registered par_err.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_deser_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_base_s, shifted_s;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_base_s;
  logic                  order_q, order_d, order_s;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  done_s;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                     input logic b, input logic msb);
    if (msb) begin
      return {sr[DATA_WIDTH-2:0], b};
    end else begin
      return {b, sr[DATA_WIDTH-1:1]};
    end
  endfunction

`ifdef DESER_PARITY_EN
  localparam logic [0:0]    ST_COLLECT = 1'b0;
  localparam logic [0:0]    ST_PARITY  = 1'b1;
  localparam logic [CW-1:0] PAR_SLOT   = CW'(DATA_WIDTH);

  logic [0:0] state_s;
  logic       par_err_q, par_err_d;

  function automatic logic parity_err(input logic [DATA_WIDTH-1:0] word,
                                      input logic pbit, input logic ptype);
    return ^word ^ pbit ^ ptype;
  endfunction

  assign state_s     = (cnt_base_s == PAR_SLOT) ? ST_PARITY : ST_COLLECT;
  assign bus.par_err = par_err_q;
`else
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
`endif

  // frame_start restarts the word, so a strobe in the same cycle lands as bit 0 of the new frame
  assign order_s    = bus.frame_start ? bus.msb_first : order_q;
  assign sr_base_s  = bus.frame_start ? {DATA_WIDTH{1'b0}} : sr_q;
  assign cnt_base_s = bus.frame_start ? {CW{1'b0}} : cnt_q;
  assign shifted_s  = shift_in(sr_base_s, bus.sampled_bit, order_s);

  // Bit collection and word completion
  always_comb begin
    sr_d    = sr_base_s;
    cnt_d   = cnt_base_s;
    order_d = order_s;
    pdata_d = pdata_q;
    done_s  = 1'b0;
`ifdef DESER_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (bus.deser_en) begin
`ifdef DESER_PARITY_EN
      case (state_s)
        ST_PARITY: begin
          done_s    = 1'b1;
          cnt_d     = {CW{1'b0}};
          pdata_d   = sr_base_s;
          par_err_d = parity_err(sr_base_s, bus.sampled_bit, bus.par_type);
        end
        ST_COLLECT: begin
          sr_d  = shifted_s;
          cnt_d = cnt_base_s + CW'(1);
        end
        default: begin
          sr_d  = {DATA_WIDTH{1'b0}};
          cnt_d = {CW{1'b0}};
        end
      endcase
`else
      sr_d = shifted_s;
      if (cnt_base_s == LAST_BIT) begin
        done_s  = 1'b1;
        cnt_d   = {CW{1'b0}};
        pdata_d = shifted_s;
      end else begin
        cnt_d = cnt_base_s + CW'(1);
      end
`endif
    end else begin
      sr_d  = sr_base_s;
      cnt_d = cnt_base_s;
    end
  end

  // Output handshake: a completing word wins over a same-edge transfer
  always_comb begin
    overrun_d = 1'b0;
    if (done_s) begin
      valid_d   = 1'b1;
      overrun_d = valid_q & ~bus.data_ready;
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q      <= {DATA_WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      order_q   <= 1'b0;
      pdata_q   <= {DATA_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      order_q   <= order_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef DESER_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: W=8, W=5 and W=16 instances checked every cycle against a word-level model.
// Also works with DESER_PARITY_EN defined.
module tb_uart_rx_deser;
  localparam int NI = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic sb [NI];
  logic en [NI];
  logic fs [NI];
  logic msb[NI];
  logic rdy[NI];
`ifdef DESER_PARITY_EN
  logic pt [NI];
`endif

  uart_rx_deser_if #(.DATA_WIDTH(8))  if8  ();
  uart_rx_deser_if #(.DATA_WIDTH(5))  if5  ();
  uart_rx_deser_if #(.DATA_WIDTH(16)) if16 ();

  assign if8.sampled_bit  = sb[0];
  assign if8.deser_en     = en[0];
  assign if8.frame_start  = fs[0];
  assign if8.msb_first    = msb[0];
  assign if8.data_ready   = rdy[0];
  assign if5.sampled_bit  = sb[1];
  assign if5.deser_en     = en[1];
  assign if5.frame_start  = fs[1];
  assign if5.msb_first    = msb[1];
  assign if5.data_ready   = rdy[1];
  assign if16.sampled_bit = sb[2];
  assign if16.deser_en    = en[2];
  assign if16.frame_start = fs[2];
  assign if16.msb_first   = msb[2];
  assign if16.data_ready  = rdy[2];
`ifdef DESER_PARITY_EN
  assign if8.par_type  = pt[0];
  assign if5.par_type  = pt[1];
  assign if16.par_type = pt[2];
`endif

  uart_rx_deser #(.DATA_WIDTH(8))  dut8  (.CLK(CLK), .RST(RST), .bus(if8));
  uart_rx_deser #(.DATA_WIDTH(5))  dut5  (.CLK(CLK), .RST(RST), .bus(if5));
  uart_rx_deser #(.DATA_WIDTH(16)) dut16 (.CLK(CLK), .RST(RST), .bus(if16));

  // Word-level model: bits received in the current frame, assembled by position when complete
  int          wd [NI] = '{8, 5, 16};
  int          cnt_m [NI];
  bit          ord_m [NI];
  bit          val_m [NI];
  bit          ovr_m [NI];
  bit          pe_m  [NI];
  logic [15:0] pd_m  [NI];
  bit          bits_m[NI][16];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int k);
    logic [15:0] w = 16'h0;
    for (int i = 0; i < wd[k]; i++) begin
      if (bits_m[k][i]) w = w | (ord_m[k] ? (16'h1 << (wd[k] - 1 - i)) : (16'h1 << i));
    end
    return w;
  endfunction

  task automatic model_step(input int k);
    bit          done = 1'b0;
    bit          vold = val_m[k];
    logic [15:0] w    = pd_m[k];
    bit          pe   = pe_m[k];
    if (RST) begin
      cnt_m[k] = 0; ord_m[k] = 1'b0; val_m[k] = 1'b0;
      ovr_m[k] = 1'b0; pe_m[k] = 1'b0; pd_m[k] = 16'h0;
      return;
    end
    if (fs[k]) begin
      cnt_m[k] = 0;
      ord_m[k] = msb[k];
    end
    if (en[k]) begin
`ifdef DESER_PARITY_EN
      if (cnt_m[k] == wd[k]) begin
        w    = word_of(k);
        pe   = (($countones(w) + int'(sb[k]) + int'(pt[k])) % 2) == 1;
        done = 1'b1;
        cnt_m[k] = 0;
      end else begin
        bits_m[k][cnt_m[k]] = sb[k];
        cnt_m[k]++;
      end
`else
      bits_m[k][cnt_m[k]] = sb[k];
      cnt_m[k]++;
      if (cnt_m[k] == wd[k]) begin
        w    = word_of(k);
        done = 1'b1;
        cnt_m[k] = 0;
      end
`endif
    end
    ovr_m[k] = 1'b0;
    if (done) begin
      ovr_m[k] = vold && !rdy[k];
      val_m[k] = 1'b1;
      pd_m[k]  = w;
      pe_m[k]  = pe;
    end else if (vold && rdy[k]) begin
      val_m[k] = 1'b0;
    end
  endtask

  function automatic logic [15:0] dut_pdata(input int k);
    case (k)
      0:       return 16'(if8.P_DATA);
      1:       return 16'(if5.P_DATA);
      default: return if16.P_DATA;
    endcase
  endfunction

  function automatic logic [2:0] dut_flags(input int k);
    logic [2:0] f;
    case (k)
      0:       f = {if8.data_valid, if8.overrun, 1'b0};
      1:       f = {if5.data_valid, if5.overrun, 1'b0};
      default: f = {if16.data_valid, if16.overrun, 1'b0};
    endcase
`ifdef DESER_PARITY_EN
    case (k)
      0:       f[0] = if8.par_err;
      1:       f[0] = if5.par_err;
      default: f[0] = if16.par_err;
    endcase
`endif
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("u%0d P_DATA", k), dut_pdata(k), pd_m[k]);
        check($sformatf("u%0d data_valid", k), 16'(dut_flags(k)[2]), 16'(val_m[k]));
        check($sformatf("u%0d overrun", k), 16'(dut_flags(k)[1]), 16'(ovr_m[k]));
`ifdef DESER_PARITY_EN
        check($sformatf("u%0d par_err", k), 16'(dut_flags(k)[0]), 16'(pe_m[k]));
`endif
      end
    end
  end

  // Directed helpers for the W=8 instance; each is entered just after a falling edge
  task automatic bit0(input logic b, input logic f);
    sb[0] = b; en[0] = 1'b1; fs[0] = f;
    @(negedge CLK);
    en[0] = 1'b0; fs[0] = 1'b0;
  endtask

  task automatic fstart0(input logic m);
    msb[0] = m; fs[0] = 1'b1;
    @(negedge CLK);
    fs[0] = 1'b0;
  endtask

  task automatic consume0();
    rdy[0] = 1'b1;
    @(negedge CLK);
    rdy[0] = 1'b0;
  endtask

  task automatic data0(input logic [7:0] w, input logic m, input logic fs1, input logic rl);
    logic [7:0] wv = w;
    msb[0] = m;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) rdy[0] = rl;
      bit0(m ? wv[7 - i] : wv[i], fs1 && (i == 0));
    end
    rdy[0] = 1'b0;
  endtask

  task automatic send_word0(input logic [7:0] w, input logic m, input logic fs1, input logic rl);
`ifdef DESER_PARITY_EN
    data0(w, m, fs1, 1'b0);
    rdy[0] = rl;
    bit0(^w ^ pt[0], 1'b0);
    rdy[0] = 1'b0;
`else
    data0(w, m, fs1, rl);
`endif
  endtask

  task automatic rand_run(input int k, input int n);
    for (int c = 0; c < n; c++) begin
      if (k == 0) begin
        en[k]  = ($urandom % 4) != 0;
        fs[k]  = ($urandom % 50) == 0;
        msb[k] = 1'($urandom % 2);
        rdy[k] = 1'($urandom % 2);
      end else begin
        en[k]  = 1'b1;
        fs[k]  = (c == 0);
        msb[k] = (k == 2);
        rdy[k] = 1'b1;
      end
      sb[k] = 1'($urandom % 2);
`ifdef DESER_PARITY_EN
      pt[k] = 1'($urandom % 2);
`endif
      @(negedge CLK);
    end
    en[k] = 1'b0; fs[k] = 1'b0; rdy[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      sb[k] = 1'b0; en[k] = 1'b0; fs[k] = 1'b0; msb[k] = 1'b0; rdy[k] = 1'b0;
`ifdef DESER_PARITY_EN
      pt[k] = 1'b0;
`endif
      cnt_m[k] = 0; ord_m[k] = 1'b0; val_m[k] = 1'b0; ovr_m[k] = 1'b0;
      pe_m[k] = 1'b0; pd_m[k] = 16'h0;
      for (int i = 0; i < 16; i++) bits_m[k][i] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset P_DATA", 16'(if8.P_DATA), 16'h0000);
    check("reset data_valid", 16'(if8.data_valid), 16'h0000);
    check("reset overrun", 16'(if8.overrun), 16'h0000);

    fstart0(1'b0);
    send_word0(8'hA5, 1'b0, 1'b0, 1'b0);
    check("lsb A5 P_DATA", 16'(if8.P_DATA), 16'h00A5);
    check("lsb A5 valid", 16'(if8.data_valid), 16'h0001);
    consume0();
    check("after ready valid", 16'(if8.data_valid), 16'h0000);
    check("after ready P_DATA hold", 16'(if8.P_DATA), 16'h00A5);

    fstart0(1'b1);
    send_word0(8'hA5, 1'b1, 1'b0, 1'b0);
    check("msb A5 P_DATA", 16'(if8.P_DATA), 16'h00A5);
    consume0();
    send_word0(8'hC0, 1'b1, 1'b0, 1'b0);
    check("msb C0 P_DATA", 16'(if8.P_DATA), 16'h00C0);
    consume0();

    fstart0(1'b0);
    send_word0(8'h3C, 1'b0, 1'b0, 1'b0);
    check("first word no overrun", 16'(if8.overrun), 16'h0000);
    send_word0(8'h81, 1'b0, 1'b0, 1'b0);
    check("overrun pulse", 16'(if8.overrun), 16'h0001);
    check("overrun newest wins", 16'(if8.P_DATA), 16'h0081);
    check("overrun valid held", 16'(if8.data_valid), 16'h0001);
    @(negedge CLK);
    check("overrun one cycle", 16'(if8.overrun), 16'h0000);
    send_word0(8'h3C, 1'b0, 1'b0, 1'b1);
    check("ready on completion no overrun", 16'(if8.overrun), 16'h0000);
    check("ready on completion valid", 16'(if8.data_valid), 16'h0001);
    check("ready on completion P_DATA", 16'(if8.P_DATA), 16'h003C);
    consume0();

    for (int i = 0; i < 5; i++) bit0(1'($urandom % 2), 1'b0);
    check("partial no valid", 16'(if8.data_valid), 16'h0000);
    fstart0(1'b0);
    send_word0(8'h5A, 1'b0, 1'b0, 1'b0);
    check("after abort P_DATA", 16'(if8.P_DATA), 16'h005A);
    consume0();

    send_word0(8'hE1, 1'b0, 1'b1, 1'b0);
    check("frame_start with strobe", 16'(if8.P_DATA), 16'h00E1);
    for (int i = 0; i < 4; i++) bit0(1'b1, 1'b0);
    RST = 1'b1;
    #1;
    check("async reset P_DATA", 16'(if8.P_DATA), 16'h0000);
    check("async reset valid", 16'(if8.data_valid), 16'h0000);
    check("async reset overrun", 16'(if8.overrun), 16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    send_word0(8'h96, 1'b0, 1'b0, 1'b0);
    check("after reset word", 16'(if8.P_DATA), 16'h0096);
    consume0();

`ifdef DESER_PARITY_EN
    pt[0] = 1'b0;
    fstart0(1'b0);
    data0(8'h07, 1'b0, 1'b0, 1'b0);
    bit0(1'b1, 1'b0);
    check("even pbit1 par_err", 16'(if8.par_err), 16'h0000);
    consume0();
    data0(8'h07, 1'b0, 1'b0, 1'b0);
    bit0(1'b0, 1'b0);
    check("even pbit0 par_err", 16'(if8.par_err), 16'h0001);
    check("parity error still valid", 16'(if8.data_valid), 16'h0001);
    consume0();
    pt[0] = 1'b1;
    data0(8'h07, 1'b0, 1'b0, 1'b0);
    bit0(1'b0, 1'b0);
    check("odd pbit0 par_err", 16'(if8.par_err), 16'h0000);
    consume0();
`endif

    fork
      rand_run(0, 2000);
      rand_run(1, 2000);
      rand_run(2, 2000);
    join
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
